// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath blocks: divider FSM states and
// the operand widths that match the 8x8 multiplier.
`timescale 1ns/1ps
package fir_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DIVIDEND_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_16by8_seq_if.sv
// Request/result bundle of the sequential divider; master drives the
// operands and start, slave returns status and results.
`timescale 1ns/1ps
interface div_16by8_seq_if
    import fir_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
);

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_16by8_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial
// subtract the divisor, keep or restore, and emit the quotient bit.
`timescale 1ns/1ps
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_rem,
    output logic                 o_q_bit
);

    logic [DIVISOR_W:0]   w_shifted;
    logic [DIVISOR_W+1:0] w_diff;
    logic                 w_unused_bit;

    assign w_shifted = {i_rem, i_bit};
    // One guard bit beyond the shifted remainder makes the sign of the trial
    // subtract explicit; the remainder itself never exceeds DIVISOR_W bits.
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign o_q_bit   = ~w_diff[DIVISOR_W+1];
    assign o_rem     = o_q_bit ? w_diff[DIVISOR_W-1:0] : w_shifted[DIVISOR_W-1:0];

    assign w_unused_bit = w_diff[DIVISOR_W];

endmodule

// File: rtl/div_16by8_seq.sv
// Sequential restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and registered results.
`timescale 1ns/1ps
module div_16by8_seq
    import fir_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    div_16by8_seq_if.slave bus
);

    localparam int CW = cnt_width(DIVIDEND_W);

    div_state_t            r_state;
    div_state_t            w_state_next;
    logic                  w_accept;
    logic                  w_zero;
    logic                  w_last;

    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dsr;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [CW-1:0]         r_count;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_dbz;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;

    logic [DIVISOR_W-1:0]  w_rem_next;
    logic                  w_q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[DIVIDEND_W-1]),
        .i_divisor (r_dsr),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_zero       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        w_zero       = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_accept     = 1'b1;
                        w_state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (r_count == '0) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state <= w_state_next;
            // Status flags mirror the state being entered so they line up with it.
            r_busy  <= (w_state_next == ST_CALC);
            r_done  <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_dvd       <= bus.dividend;
                r_dsr       <= bus.divisor;
                r_rem       <= '0;
                r_quot      <= '0;
                r_count     <= CW'(DIVIDEND_W - 1);
                r_quotient  <= '0;
                r_remainder <= '0;
                r_dbz       <= 1'b0;
            end else if (w_zero) begin
                r_quotient  <= '1;
                r_remainder <= bus.dividend[DIVISOR_W-1:0];
                r_dbz       <= 1'b1;
            end else if (r_state == ST_CALC) begin
                r_dvd   <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
                r_rem   <= w_rem_next;
                r_quot  <= {r_quot[DIVIDEND_W-2:0], w_q_bit};
                r_count <= r_count - CW'(1);
                if (w_last) begin
                    r_quotient  <= {r_quot[DIVIDEND_W-2:0], w_q_bit};
                    r_remainder <= w_rem_next;
                end
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_16by8_seq.sv
// Directed and sweep bench for the sequential 16/8 divider.
`timescale 1ns/1ps
module tb_div_16by8_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div_16by8_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

    div_16by8_seq #(
        .DIVIDEND_W (16),
        .DIVISOR_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and waits for done; lat stays 0 if done never comes.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output int lat, output int bcnt);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        lat  = 0;
        bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                bus.start    = 1'b0;
                bus.dividend = ~a;
                bus.divisor  = ~b;
            end
            if (bus.busy === 1'b1) bcnt++;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dividend = 16'd0; bus.divisor = 8'd0;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
        checks++; if (bus.quotient !== 16'd0) begin errors++; $display("FAIL reset_quot got %0h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL reset_rem got %0h want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", bus.div_by_zero); end
        rst_n = 1'b1;
        tick();
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        int lat, bc;
        run_div(16'd40000, 8'd200, lat, bc);
        $display("basic: 40000 / 200 -> %0d r %0d lat %0d busy %0d", bus.quotient, bus.remainder, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
        checks++; if (bus.quotient !== 16'd200) begin errors++; $display("FAIL basic_quot got %0d want 200", bus.quotient); end
        checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL basic_rem got %0d want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %0b want 0", bus.div_by_zero); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b want 0", bus.done); end
        tick(); tick();
        checks++; if (bus.quotient !== 16'd200) begin errors++; $display("FAIL basic_hold_quot got %0d want 200", bus.quotient); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_tab [3] = '{16'd65535, 16'd1000, 16'd5};
        logic [7:0]  b_tab [3] = '{8'd255, 8'd7, 8'd10};
        logic [15:0] q_tab [3] = '{16'd257, 16'd142, 16'd0};
        logic [7:0]  r_tab [3] = '{8'd0, 8'd6, 8'd5};
        int idx;
        int last;
        idx  = 0;
        last = 0;
        bus.dividend = a_tab[0];
        bus.divisor  = b_tab[0];
        bus.start    = 1'b1;
        for (int n = 1; n <= 120 && idx < 3; n++) begin
            tick();
            if (bus.done === 1'b1) begin
                $display("b2b: %0d / %0d -> %0d r %0d at cycle %0d", a_tab[idx], b_tab[idx], bus.quotient, bus.remainder, n);
                checks++; if (bus.quotient !== q_tab[idx]) begin errors++; $display("FAIL b2b_quot[%0d] got %0d want %0d", idx, bus.quotient, q_tab[idx]); end
                checks++; if (bus.remainder !== r_tab[idx]) begin errors++; $display("FAIL b2b_rem[%0d] got %0d want %0d", idx, bus.remainder, r_tab[idx]); end
                checks++;
                if (idx == 0) begin
                    if (n !== 17) begin errors++; $display("FAIL b2b_first_latency got %0d want 17", n); end
                end else begin
                    if (n - last !== 18) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 18", idx, n - last); end
                end
                last = n;
                idx++;
                if (idx < 3) begin
                    bus.dividend = a_tab[idx];
                    bus.divisor  = b_tab[idx];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_timeout got %0d results want 3", idx); end
        tick(); tick();
    endtask

    task automatic test_div_zero();
        logic busy_seen;
        busy_seen = 1'b0;
        bus.dividend = 16'd1234;
        bus.divisor  = 8'd0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.busy !== 1'b0) busy_seen = 1'b1;
        $display("divzero: 1234 / 0 -> %0h r %0h dbz %0b done %0b", bus.quotient, bus.remainder, bus.div_by_zero, bus.done);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL dz_done got %0b want 1", bus.done); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b want 1", bus.div_by_zero); end
        checks++; if (bus.quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_quot got %0h want ffff", bus.quotient); end
        checks++; if (bus.remainder !== 8'hD2) begin errors++; $display("FAIL dz_rem got %0h want d2", bus.remainder); end
        tick();
        if (bus.busy !== 1'b0) busy_seen = 1'b1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dz_done_pulse got %0b want 0", bus.done); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %0b want 1", bus.div_by_zero); end
        tick();
        if (bus.busy !== 1'b0) busy_seen = 1'b1;
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL dz_busy got %0b want 0", busy_seen); end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic busy_seen;
        lat = 0;
        busy_seen = 1'b0;
        bus.dividend = 16'd50000;
        bus.divisor  = 8'd9;
        bus.start    = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) bus.start = 1'b0;
            if (n == 4) begin bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 8'd3; end
            if (n == 5) bus.start = 1'b0;
            if (bus.done === 1'b1) begin lat = n; break; end
        end
        $display("ignore: 50000 / 9 -> %0d r %0d lat %0d", bus.quotient, bus.remainder, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL ign_latency got %0d want 17", lat); end
        checks++; if (bus.quotient !== 16'd5555) begin errors++; $display("FAIL ign_quot got %0d want 5555", bus.quotient); end
        checks++; if (bus.remainder !== 8'd5) begin errors++; $display("FAIL ign_rem got %0d want 5", bus.remainder); end
        for (int n = 0; n < 4; n++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL ign_no_queue got %0b want 0", busy_seen); end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        bus.dividend = 16'd7;
        bus.divisor  = 8'd0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("rst_clear: q %0h r %0h dbz %0b", bus.quotient, bus.remainder, bus.div_by_zero);
        checks++; if (bus.quotient !== 16'd0) begin errors++; $display("FAIL rst_clr_quot got %0h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL rst_clr_rem got %0h want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_clr_dbz got %0b want 0", bus.div_by_zero); end
        tick();

        bus.dividend = 16'd60000;
        bus.divisor  = 8'd13;
        bus.start    = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 1) bus.start = 1'b0;
        end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %0b want 1", bus.busy); end
        rst_n = 1'b0;
        tick();
        $display("abort: busy %0b done %0b q %0d", bus.busy, bus.done, bus.quotient);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got %0b want 0", bus.done); end

        bus.dividend = 16'd300;
        bus.divisor  = 8'd16;
        bus.start    = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %0b want 0", bus.busy); end
        rst_n = 1'b1;
        run_div(16'd300, 8'd16, lat, bc);
        $display("after_abort: 300 / 16 -> %0d r %0d lat %0d", bus.quotient, bus.remainder, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL post_latency got %0d want 17", lat); end
        checks++; if (bus.quotient !== 16'd18) begin errors++; $display("FAIL post_quot got %0d want 18", bus.quotient); end
        checks++; if (bus.remainder !== 8'd12) begin errors++; $display("FAIL post_rem got %0d want 12", bus.remainder); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0]  x, y, d, exp_r;
        logic [15:0] p, exp_q;
        int lat, bc;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(1, 255));
            p = 16'(x) * 16'(y);
            exp_q = p / 16'(d);
            exp_r = 8'(p % 16'(d));
            run_div(p, d, lat, bc);
            tick();
            $display("rand %0d: %0d / %0d -> %0d r %0d", i, p, d, bus.quotient, bus.remainder);
            checks++;
            if (lat !== 17 || bus.quotient !== exp_q || bus.remainder !== exp_r ||
                (int'(bus.quotient) * int'(d) + int'(bus.remainder)) != int'(p) ||
                bus.remainder >= d) begin
                errors++;
                $display("FAIL rand[%0d] %0d/%0d got q %0d r %0d lat %0d want q %0d r %0d lat 17",
                         i, p, d, bus.quotient, bus.remainder, lat, exp_q, exp_r);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor = 8'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
